// File: rtl/tiny16_mem_pkg.sv
// Shared definitions for the tiny16 memory subsystem (memory + arbiter).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tiny16_mem_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 16;

    // Requester index width; wide enough for up to 4 requesters.
    localparam int REQ_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req (request vector), ptr (search start), winner (index), any_req.
module rr_select
    import tiny16_mem_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] ptr,
    output logic [REQ_IDX_W-1:0] winner,
    output logic                 any_req
);

    logic found;
    int   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner = REQ_IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one tiny16 memory among NUM_REQ requesters, one transaction at a time.
// Latency: gnt 1 cycle after req is sampled in IDLE; read rvalid 2 cycles after sampling.
// Backpressure: requesters hold req/we/addr/wdata until gnt; req is sampled only while IDLE.
// Ports: clk, rst (async active-low); req/we/addr/wdata in, gnt/rvalid/rdata/busy out;
//        mem_in_* drives the memory write port, mem_out_* the read port (data returns next cycle).
module mem_arbiter
    import tiny16_mem_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          mem_in_en,
    output logic [ADDR_WIDTH-1:0]         mem_in_addr,
    output logic [DATA_WIDTH-1:0]         mem_in_data,
    output logic                          mem_out_en,
    output logic [ADDR_WIDTH-1:0]         mem_out_addr,
    input  logic [DATA_WIDTH-1:0]         mem_out_data
);

    arb_state_t             state_q, state_d;
    logic [REQ_IDX_W-1:0]   ptr_q;
    logic [REQ_IDX_W-1:0]   win_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    logic [REQ_IDX_W-1:0]   sel;
    logic                   any_req;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (sel),
        .any_req (any_req)
    );

    // All request fields are captured at the IDLE sampling edge, so later
    // changes on the requester side (including dropping req) cannot affect
    // a transaction already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                win_q   <= sel;
                we_q    <= we[sel];
                addr_q  <= addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= wdata[sel*DATA_WIDTH +: DATA_WIDTH];
                ptr_q   <= (sel == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    // Outputs decode only from state and latched fields, so there is no
    // combinational path from req to gnt or to the memory ports.
    always_comb begin
        state_d      = state_q;
        gnt          = '0;
        rvalid       = '0;
        rdata        = '0;
        busy         = 1'b0;
        mem_in_en    = 1'b0;
        mem_in_addr  = '0;
        mem_in_data  = '0;
        mem_out_en   = 1'b0;
        mem_out_addr = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                gnt  = NUM_REQ'(1) << win_q;
                if (we_q) begin
                    mem_in_en   = 1'b1;
                    mem_in_addr = addr_q;
                    mem_in_data = wdata_q;
                    state_d     = IDLE;
                end else begin
                    mem_out_en   = 1'b1;
                    mem_out_addr = addr_q;
                    state_d      = RDATA;
                end
            end
            RDATA: begin
                busy    = 1'b1;
                rvalid  = NUM_REQ'(1) << win_q;
                rdata   = mem_out_data;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
